ltc2992_sense_avg: RTL and testbench

Post-processing stage downstream of the LTC2992 I2C read path. Takes each completed 16-bit register read with its channel tag, converts the 12-bit ADC code to millivolts, averages 2^P_AVG_LOG2 samples per channel, and raises per-channel over-voltage alarms with hysteresis. Its outputs drive the status LEDs and any host readback.

---
 rtl/ltc2992_sense_avg.sv | 139 +++++++++++++
 tb/tb_ltc2992_sense_avg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ltc2992_sense_avg.sv
// LTC2992 read post-processing: scales 12-bit codes to mV, averages per channel,
// and drives hysteretic over-voltage alarms plus status LEDs.
module ltc2992_sense_avg #(
  parameter int P_AVG_LOG2 = 2,
  parameter int P_HI_MV    = 3600,
  parameter int P_LO_MV    = 3000
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_data_valid,
  input  logic [15:0] I_read_data,
  input  logic        I_chan,
  input  logic        I_clear,
  output logic        O_avg_valid,
  output logic        O_avg_chan,
  output logic [16:0] O_avg_mv,
  output logic [1:0]  O_alarm,
  output logic [7:0]  O_err_cnt,
  output logic [3:0]  O_led_out
);

  localparam int ACC_W = 17 + P_AVG_LOG2;
  // A zero-width counter is not legal, so P_AVG_LOG2=0 keeps one bit pinned at 0.
  localparam int CNT_W = (P_AVG_LOG2 == 0) ? 1 : P_AVG_LOG2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << P_AVG_LOG2) - 1);

  logic        s1_valid_q;
  logic [11:0] s1_code_q;
  logic        s1_chan_q;
  logic [7:0]  err_cnt_q;

  logic        sample_ok;
  logic        sample_bad;
  assign sample_ok  = I_data_valid && !I_clear && (I_read_data[3:0] == 4'd0);
  assign sample_bad = I_data_valid && !I_clear && (I_read_data[3:0] != 4'd0);

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= 12'd0;
      s1_chan_q  <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      s1_valid_q <= sample_ok;
      if (I_data_valid && !I_clear) begin
        s1_code_q <= I_read_data[15:4];
        s1_chan_q <= I_chan;
      end
      if (sample_bad && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  logic [16:0]            code_ext;
  logic [16:0]            mv_s2;
  logic [1:0][ACC_W-1:0]  acc_all;
  logic [1:0][CNT_W-1:0]  cnt_all;
  logic [ACC_W-1:0]       acc_d;
  logic                   last_s2;
  logic                   emit_s2;

  // code*25 as a shift-add: 16x + 8x + 1x.
  assign code_ext = {5'd0, s1_code_q};
  assign mv_s2    = s1_chan_q ? {6'd0, s1_code_q[11:1]}
                              : (code_ext << 4) + (code_ext << 3) + code_ext;
  assign acc_d    = acc_all[s1_chan_q] + ACC_W'(mv_s2);
  assign last_s2  = (cnt_all[s1_chan_q] == CNT_LAST);
  assign emit_s2  = s1_valid_q && last_s2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hit;

    assign hit         = s1_valid_q && (s1_chan_q == 1'(gi));
    assign acc_all[gi] = acc_q;
    assign cnt_all[gi] = cnt_q;

    // Clear has priority; a completing sample still emits via emit_s2.
    always_ff @(posedge I_clk) begin
      if (I_rst || I_clear) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (hit) begin
        if (last_s2) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  logic        avg_valid_q;
  logic        avg_chan_q;
  logic [16:0] avg_mv_q;
  logic [1:0]  alarm_q;
  logic        hb_q;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      avg_valid_q <= 1'b0;
      avg_chan_q  <= 1'b0;
      avg_mv_q    <= 17'd0;
    end else begin
      avg_valid_q <= emit_s2;
      if (emit_s2) begin
        avg_chan_q <= s1_chan_q;
        avg_mv_q   <= 17'(acc_d >> P_AVG_LOG2);
      end
    end
  end

  // Hysteresis: between the two thresholds the alarm keeps its previous state.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      alarm_q <= 2'b00;
      hb_q    <= 1'b0;
    end else if (avg_valid_q) begin
      hb_q <= ~hb_q;
      if (avg_mv_q > 17'(P_HI_MV)) begin
        alarm_q[avg_chan_q] <= 1'b1;
      end else if (avg_mv_q < 17'(P_LO_MV)) begin
        alarm_q[avg_chan_q] <= 1'b0;
      end
    end
  end

  assign O_avg_valid = avg_valid_q;
  assign O_avg_chan  = avg_chan_q;
  assign O_avg_mv    = avg_mv_q;
  assign O_alarm     = alarm_q;
  assign O_err_cnt   = err_cnt_q;
  assign O_led_out   = {alarm_q[1], alarm_q[0], ~alarm_q[1] & ~alarm_q[0], hb_q};

endmodule

// File: tb/tb_ltc2992_sense_avg.sv
// Scoreboard bench for ltc2992_sense_avg: directed cases plus random traffic
// checked against an arithmetic reference model.
module tb_ltc2992_sense_avg;

  localparam int NAVG = 4;

  logic        clk = 1'b0;
  logic        I_rst = 1'b1;
  logic        I_data_valid = 1'b0;
  logic [15:0] I_read_data = 16'd0;
  logic        I_chan = 1'b0;
  logic        I_clear = 1'b0;
  logic        O_avg_valid;
  logic        O_avg_chan;
  logic [16:0] O_avg_mv;
  logic [1:0]  O_alarm;
  logic [7:0]  O_err_cnt;
  logic [3:0]  O_led_out;

  ltc2992_sense_avg #(.P_AVG_LOG2(2), .P_HI_MV(3600), .P_LO_MV(3000)) dut (
    .I_clk(clk), .I_rst(I_rst), .I_data_valid(I_data_valid),
    .I_read_data(I_read_data), .I_chan(I_chan), .I_clear(I_clear),
    .O_avg_valid(O_avg_valid), .O_avg_chan(O_avg_chan), .O_avg_mv(O_avg_mv),
    .O_alarm(O_alarm), .O_err_cnt(O_err_cnt), .O_led_out(O_led_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: running sums per channel, plain arithmetic.
  typedef struct {
    int         cyc;
    logic       ch;
    int         mv;
    logic [1:0] alarm;
    logic [3:0] led;
  } exp_t;

  exp_t       expq[$];
  int         msum[2];
  int         mcnt[2];
  int         merr;
  logic [1:0] malarm;
  logic       mhb;

  function automatic void model_reset();
    msum[0] = 0; msum[1] = 0; mcnt[0] = 0; mcnt[1] = 0;
    merr = 0; malarm = 2'b00; mhb = 1'b0;
    expq.delete();
  endfunction

  function automatic void model_sample(logic ch, logic [15:0] d, int c);
    int   code, mv, avg;
    exp_t e;
    if (d[3:0] != 4'd0) begin
      if (merr < 255) merr++;
      return;
    end
    code = int'(d[15:4]);
    mv   = ch ? code / 2 : code * 25;
    msum[ch] += mv;
    mcnt[ch]++;
    if (mcnt[ch] == NAVG) begin
      avg = msum[ch] / NAVG;
      if (avg > 3600) malarm[ch] = 1'b1;
      else if (avg < 3000) malarm[ch] = 1'b0;
      mhb = ~mhb;
      e.cyc = c + 2; e.ch = ch; e.mv = avg; e.alarm = malarm;
      e.led = {malarm[1], malarm[0], ~malarm[1] & ~malarm[0], mhb};
      expq.push_back(e);
      msum[ch] = 0;
      mcnt[ch] = 0;
    end
  endfunction

  // Monitor: pops on every output pulse, checks alarm/LEDs one cycle later.
  logic       pend = 1'b0;
  logic [1:0] pend_alarm;
  logic [3:0] pend_led;
  always @(negedge clk) begin
    exp_t e;
    if (I_rst) pend = 1'b0;
    if (pend) begin
      chk("alarm", int'(O_alarm), int'(pend_alarm));
      chk("led", int'(O_led_out), int'(pend_led));
      pend = 1'b0;
    end
    if (O_avg_valid === 1'b1) begin
      if (expq.size() == 0) begin
        chk("unexpected_avg_valid", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("avg_latency", cyc, e.cyc);
        chk("avg_chan", int'(O_avg_chan), int'(e.ch));
        chk("avg_mv", int'(O_avg_mv), e.mv);
        pend = !I_rst;
        pend_alarm = e.alarm;
        pend_led = e.led;
      end
    end
  end

  task automatic send(input logic ch, input logic [15:0] d);
    @(negedge clk);
    I_clear = 1'b0; I_data_valid = 1'b1; I_chan = ch; I_read_data = d;
    model_sample(ch, d, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      I_data_valid = 1'b0; I_clear = 1'b0;
    end
  endtask

  task automatic send_n(input logic ch, input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) send(ch, d);
  endtask

  task automatic do_clear();
    @(negedge clk);
    I_data_valid = 1'b0; I_clear = 1'b1;
    msum[0] = 0; msum[1] = 0; mcnt[0] = 0; mcnt[1] = 0;
    idle(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    I_data_valid = 1'b0; I_clear = 1'b0; I_rst = 1'b1;
    model_reset();
    idle(2);
    I_rst = 1'b0;
  endtask

  task automatic check_reset_state();
    chk("rst_avg_valid", int'(O_avg_valid), 0);
    chk("rst_avg_chan", int'(O_avg_chan), 0);
    chk("rst_avg_mv", int'(O_avg_mv), 0);
    chk("rst_alarm", int'(O_alarm), 0);
    chk("rst_err_cnt", int'(O_err_cnt), 0);
    chk("rst_led", int'(O_led_out), 4'b0010);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] d;
    logic        ch;
    model_reset();
    idle(3);
    check_reset_state();
    I_rst = 1'b0;
    idle(2);

    send_n(1'b0, 16'h0840, 4); idle(4);          // 3300 mV
    send_n(1'b1, 16'h7FF0, 4); idle(4);          // 1023 mV
    send_n(1'b0, 16'h0900, 4); idle(4);          // 3600: no alarm
    send_n(1'b0, 16'h0910, 4); idle(4);          // 3625: set
    send_n(1'b0, 16'h0780, 4); idle(4);          // 3000: hold
    send_n(1'b0, 16'h0770, 4); idle(4);          // 2975: clear

    send(1'b0, 16'h0841); send(1'b0, 16'h084F); idle(3);
    chk("err_cnt_two", int'(O_err_cnt), 2);
    send_n(1'b0, 16'h0840, 4); idle(4);          // bad samples did not accumulate
    send_n(1'b1, 16'h1233, 300); idle(3);
    chk("err_cnt_sat", int'(O_err_cnt), 255);

    for (int i = 0; i < 8; i++) begin
      send(1'b0, 16'h0100);
      send(1'b1, 16'h0C80);
    end
    idle(4);

    send_n(1'b0, 16'h0840, 2); do_clear();
    send_n(1'b0, 16'h0040, 4); idle(4);          // 100 mV

    send_n(1'b0, 16'h0FF0, 3); do_reset();
    check_reset_state();
    send_n(1'b0, 16'h0040, 4); idle(4);

    send_n(1'b0, 16'hFFF0, 4); idle(4);          // 102375 mV

    for (int i = 0; i < 400; i++) begin
      ch = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) d = {12'($urandom_range(100, 180)), 4'd0};
      else d = {12'($urandom), 4'd0};
      if ($urandom_range(0, 9) == 0) d[3:0] = 4'($urandom_range(1, 15));
      send(ch, d);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      if ($urandom_range(0, 60) == 0) do_clear();
    end
    idle(6);
    chk("err_cnt_final", int'(O_err_cnt), merr);
    chk("scoreboard_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
